id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and execute-stage operand selection for the pipelined MIPS core. It captures decoded operands and control from the decode stage on each clock, supports stall (hold) and flush (bubble), and drives `SrcAE`, `SrcBE` and `ALUControlE` directly into the ALU. Optional forwarding muxes resolve RAW hazards from the MEM and WB stages.

## Interface
- `WIDTH`, 32: datapath width.
- `RA_W`, 5: register-address width.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `StallE`  in  1: hold all E registers.
- `FlushE`  in  1: load a bubble on the next edge.
- `RD1D`, `RD2D`, `SignImmD`  in  WIDTH: register-file reads and the sign-extended immediate.
- `RsD`, `RtD`, `RdD`  in  RA_W: register specifiers.
- `ALUControlD`  in  3: ALU operation.
- `ALUSrcD`, `RegDstD`, `RegWriteD`, `MemtoRegD`, `MemWriteD`  in  1: decode control.
- `ALUOutM`  in  WIDTH: MEM-stage result, the forwarding source.
- `ResultW`  in  WIDTH: WB-stage result, the forwarding source.
- `WriteRegM`, `WriteRegW`  in  RA_W: destination registers in MEM and WB.
- `RegWriteM`, `RegWriteW`  in  1: write enables in MEM and WB.
- `SrcAE`, `SrcBE`  out  WIDTH: ALU operands.
- `ALUControlE`  out  3: to the ALU.
- `WriteDataE`  out  WIDTH: store data (forwarded RD2).
- `WriteRegE`  out  RA_W: `RegDstE ? RdE : RtE`.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`  out  1: control passed downstream.
- `RsE`, `RtE`  out  RA_W: to the hazard unit.

## Operation
- Register fields: RD1, RD2, SignImm, Rs, Rt, Rd, ALUControl, ALUSrc, RegDst, RegWrite, MemtoReg, MemWrite.
- Edge priority:
  - `FlushE` has the highest priority. All fields load 0, which is a bubble: ALUControl 000, no writes.
  - `StallE` comes next. All fields hold their values.
  - Otherwise all fields load the D inputs.
- Forward select for A (B is identical, using `RtE`):
  - FWD_MEM (10) when `RegWriteM && RsE!=0 && RsE==WriteRegM`.
  - Else FWD_WB (01) when `RegWriteW && RsE!=0 && RsE==WriteRegW`.
  - Else FWD_NONE (00).
  - MEM beats WB when both match. Register 0 is never forwarded.
- Datapath:
  - `SrcAE` is the selected value of {RD1E, ResultW, ALUOutM}.
  - `WriteDataE` is the selected value of {RD2E, ResultW, ALUOutM}.
  - `SrcBE = ALUSrcE ? SignImmE : WriteDataE`.
- Widths: all values pass through unmodified. There is no arithmetic in this block.

## Timing
- Reset: asynchronous assertion clears every field to 0 immediately, without waiting for `clk`.
- Outputs while in reset or holding a bubble:
  - `SrcAE`, `SrcBE`, `WriteDataE`, `WriteRegE`, `RsE`, `RtE` = 0.
  - `ALUControlE` = 000.
  - `RegWriteE`, `MemtoRegE`, `MemWriteE` = 0.
  - Because `RsE`/`RtE` are 0, no forwarding is active.
- Reset deassertion: the first capture happens on the following rising edge.
- Latency: 1 cycle from D inputs to E outputs.
- Forwarding and the `ALUSrc` select are combinational from the registered fields and the M/W inputs, with zero added latency.
- `StallE` and `FlushE` both high on the same edge: flush wins.
- A stall may last any number of cycles. Forwarded values track the M/W inputs while stalled.
- Reset during a stall or flush: reset dominates.

## Configuration
- `ID_EX_FORWARDING_EN` defined:
  - Forwarding logic is built as described above.
- Not defined:
  - `SrcAE = RD1E`.
  - `WriteDataE = RD2E`.
  - The M/W ports remain but are unused. The hazard unit must stall instead.

## Structure
- Shared package `mips_pkg` holds:
  - The ALU control encodings: AND 000, OR 001, ADD 010, SUB 100, MUL 101, SLT 110.
  - Forward-select constants FWD_NONE/FWD_WB/FWD_MEM.
  - The `WIDTH`/`RA_W` defaults.
- Sub-module `fwd_sel` computes the 2-bit select for one operand from (src reg, M/W dest, M/W write enable). It is instantiated twice.

## Test plan
- Reset: assert `rst_n`=0 with nonzero D inputs → all outputs 0 asynchronously; after release, the first edge captures the D inputs.
- Pass-through: `RD1D`=5, `RD2D`=7, `ALUSrcD`=0, `ALUControlD`=010 → next cycle `SrcAE`=5, `SrcBE`=7, `ALUControlE`=010.
  - Then `ALUSrcD`=1, `SignImmD`=0xFFFFFFFC → `SrcBE`=0xFFFFFFFC, `WriteDataE`=7.
- Forward priority: `RsE`=3, `RegWriteM`=1, `WriteRegM`=3, `ALUOutM`=0x11, `RegWriteW`=1, `WriteRegW`=3, `ResultW`=0x22 → `SrcAE`=0x11.
  - Then drop `RegWriteM` → `SrcAE`=0x22.
  - With `RsE`=0 → `SrcAE`=`RD1E`.
- Stall/flush: capture A, then hold `StallE` for 3 cycles with new D inputs → outputs stay A.
  - Then `StallE`=1 and `FlushE`=1 → bubble: all control 0, `ALUControlE`=000.
- Config off (`ID_EX_FORWARDING_EN` undefined): repeat the forward-priority case → `SrcAE`=`RD1E`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU opcodes, forward selects,
// default datapath and register-address widths.
package mips_pkg;

  localparam int D_WIDTH = 32;
  localparam int D_RA_W  = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b100,
    ALU_MUL = 3'b101,
    ALU_SLT = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

endpackage

// File: rtl/fwd_sel.sv
// Forward select for one ALU operand.
// in: src, wreg_m/w, we_m/w; out: sel (MEM beats WB, r0 never).
module fwd_sel
  import mips_pkg::*;
#(
  parameter int RA_W = D_RA_W
) (
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] wreg_m,
  input  logic [RA_W-1:0] wreg_w,
  input  logic            we_m,
  input  logic            we_w,
  output fwd_e            sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = we_m && (src != '0)
              && (src == wreg_m);
  // masked by hit_m so the cases stay exclusive
  assign hit_w = we_w && (src != '0)
              && (src == wreg_w) && !hit_m;

  always_comb begin
    sel = FWD_NONE;
    unique case (1'b1)
      hit_m:   sel = FWD_MEM;
      hit_w:   sel = FWD_WB;
      default: sel = FWD_NONE;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register + ALU operand select; stall/flush, optional
// forwarding from M/W under ID_EX_FORWARDING_EN. Ports: D-stage
// operands/control in, M/W results in, ALU operands/control out.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = D_WIDTH,
  parameter int RA_W  = D_RA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] SignImmD,
  input  logic [RA_W-1:0]  RsD,
  input  logic [RA_W-1:0]  RtD,
  input  logic [RA_W-1:0]  RdD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [RA_W-1:0]  WriteRegM,
  input  logic [RA_W-1:0]  WriteRegW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic [WIDTH-1:0] SrcAE,
  output logic [WIDTH-1:0] SrcBE,
  output logic [2:0]       ALUControlE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [RA_W-1:0]  WriteRegE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic [RA_W-1:0]  RsE,
  output logic [RA_W-1:0]  RtE
);

  typedef struct packed {
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [RA_W-1:0]  rd;
    logic [2:0]       alu_ctl;
    logic             alu_src;
    logic             reg_dst;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
  } id_ex_t;

  id_ex_t d;
  id_ex_t q;

  assign d = '{
    rd1:        RD1D,
    rd2:        RD2D,
    imm:        SignImmD,
    rs:         RsD,
    rt:         RtD,
    rd:         RdD,
    alu_ctl:    ALUControlD,
    alu_src:    ALUSrcD,
    reg_dst:    RegDstD,
    reg_write:  RegWriteD,
    mem_to_reg: MemtoRegD,
    mem_write:  MemWriteD
  };

  // all-zero record is the bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (FlushE) begin
      q <= '0;
    end else if (!StallE) begin
      q <= d;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  fwd_e fa;
  fwd_e fb;

  fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .src    (q.rs),
    .wreg_m (WriteRegM),
    .wreg_w (WriteRegW),
    .we_m   (RegWriteM),
    .we_w   (RegWriteW),
    .sel    (fa)
  );

  fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .src    (q.rt),
    .wreg_m (WriteRegM),
    .wreg_w (WriteRegW),
    .we_m   (RegWriteM),
    .we_w   (RegWriteW),
    .sel    (fb)
  );

  always_comb begin
    SrcAE = q.rd1;
    unique case (fa)
      FWD_MEM: SrcAE = ALUOutM;
      FWD_WB:  SrcAE = ResultW;
      default: SrcAE = q.rd1;
    endcase
  end

  always_comb begin
    WriteDataE = q.rd2;
    unique case (fb)
      FWD_MEM: WriteDataE = ALUOutM;
      FWD_WB:  WriteDataE = ResultW;
      default: WriteDataE = q.rd2;
    endcase
  end
`else
  // hazard unit stalls instead; M/W ports kept for a fixed pinout
  logic unused_fwd;

  assign unused_fwd = ^{ALUOutM, ResultW,
                        WriteRegM, WriteRegW,
                        RegWriteM, RegWriteW};

  assign SrcAE      = q.rd1;
  assign WriteDataE = q.rd2;
`endif

  assign SrcBE       = q.alu_src ? q.imm : WriteDataE;
  assign ALUControlE = q.alu_ctl;
  assign WriteRegE   = q.reg_dst ? q.rd : q.rt;
  assign RegWriteE   = q.reg_write;
  assign MemtoRegE   = q.mem_to_reg;
  assign MemWriteE   = q.mem_write;
  assign RsE         = q.rs;
  assign RtE         = q.rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: per-cycle model compare
// plus directed literal checks.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        StallE, FlushE;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic [2:0]  ALUControlD;
  logic        ALUSrcD, RegDstD, RegWriteD, MemtoRegD, MemWriteD;
  logic [31:0] ALUOutM, ResultW;
  logic [4:0]  WriteRegM, WriteRegW;
  logic        RegWriteM, RegWriteW;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [2:0]  ALUControlE;
  logic [4:0]  WriteRegE, RsE, RtE;
  logic        RegWriteE, MemtoRegE, MemWriteE;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .RegWriteD(RegWriteD),
    .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUOutM(ALUOutM), .ResultW(ResultW),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
    .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .RsE(RsE), .RtE(RtE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Model: what the E stage currently holds (one instruction record)
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [2:0]  m_alu;
  logic        m_src, m_dst, m_rw, m_mr, m_mw;

  task automatic m_clear();
    {m_rd1, m_rd2, m_imm} = '0;
    {m_rs, m_rt, m_rd} = '0;
    m_alu = 3'b000;
    {m_src, m_dst, m_rw, m_mr, m_mw} = '0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || FlushE) m_clear();
    else if (!StallE) begin
      m_rd1 = RD1D; m_rd2 = RD2D; m_imm = SignImmD;
      m_rs = RsD; m_rt = RtD; m_rd = RdD;
      m_alu = ALUControlD;
      m_src = ALUSrcD; m_dst = RegDstD;
      m_rw = RegWriteD; m_mr = MemtoRegD; m_mw = MemWriteD;
    end
  end

  function automatic logic [31:0] operand(input logic [4:0] r,
                                          input logic [31:0] v);
`ifdef ID_EX_FORWARDING_EN
    if (RegWriteM && r != 0 && r == WriteRegM) return ALUOutM;
    if (RegWriteW && r != 0 && r == WriteRegW) return ResultW;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] ea, ewd;
      ea  = operand(m_rs, m_rd1);
      ewd = operand(m_rt, m_rd2);
      chk("m_SrcAE", SrcAE, ea);
      chk("m_WriteDataE", WriteDataE, ewd);
      chk("m_SrcBE", SrcBE, m_src ? m_imm : ewd);
      chk("m_ALUControlE", {29'b0, ALUControlE}, {29'b0, m_alu});
      chk("m_WriteRegE", {27'b0, WriteRegE},
          {27'b0, m_dst ? m_rd : m_rt});
      chk("m_RsRt", {22'b0, RsE, RtE}, {22'b0, m_rs, m_rt});
      chk("m_ctrl", {29'b0, RegWriteE, MemtoRegE, MemWriteE},
          {29'b0, m_rw, m_mr, m_mw});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_a"}, SrcAE, 32'h0);
    chk({n, "_b"}, SrcBE, 32'h0);
    chk({n, "_wd"}, WriteDataE, 32'h0);
    chk({n, "_alu"}, {29'b0, ALUControlE}, 32'h0);
    chk({n, "_regs"}, {17'b0, WriteRegE, RsE, RtE}, 32'h0);
    chk({n, "_ctl"}, {29'b0, RegWriteE, MemtoRegE, MemWriteE}, 32'h0);
  endtask

  task automatic async_reset(input string n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(n);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    StallE = 0; FlushE = 0;
    RD1D = 32'h1234; RD2D = 32'h5678; SignImmD = 32'h9abc;
    RsD = 5'd4; RtD = 5'd6; RdD = 5'd9;
    ALUControlD = 3'b110;
    ALUSrcD = 0; RegDstD = 1; RegWriteD = 1; MemtoRegD = 1; MemWriteD = 1;
    ALUOutM = 0; ResultW = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteM = 0; RegWriteW = 0;
    m_clear();

    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    cmp_en = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("first_cap_a", SrcAE, 32'h1234);
    chk("first_cap_wr", {27'b0, WriteRegE}, 32'd9);

    async_reset("async_rst");

    // pass-through
    RD1D = 32'd5; RD2D = 32'd7; ALUSrcD = 0; ALUControlD = 3'b010;
    RsD = 5'd1; RtD = 5'd2; RdD = 5'd8; RegDstD = 0;
    RegWriteD = 1; MemtoRegD = 0; MemWriteD = 0;
    tick();
    chk("pass_a", SrcAE, 32'd5);
    chk("pass_b", SrcBE, 32'd7);
    chk("pass_alu", {29'b0, ALUControlE}, 32'd2);
    chk("pass_wrt", {27'b0, WriteRegE}, 32'd2);
    ALUSrcD = 1; SignImmD = 32'hFFFF_FFFC;
    tick();
    chk("imm_b", SrcBE, 32'hFFFF_FFFC);
    chk("imm_wd", WriteDataE, 32'd7);

    // forwarding priority
    RsD = 5'd3; RtD = 5'd3; RD1D = 32'h99; RD2D = 32'h77; ALUSrcD = 0;
    RegWriteM = 1; WriteRegM = 5'd3; ALUOutM = 32'h11;
    RegWriteW = 1; WriteRegW = 5'd3; ResultW = 32'h22;
    tick();
`ifdef ID_EX_FORWARDING_EN
    chk("fwd_mem_a", SrcAE, 32'h11);
    chk("fwd_mem_b", SrcBE, 32'h11);
    RegWriteM = 0;
    #1;
    chk("fwd_wb_a", SrcAE, 32'h22);
    chk("fwd_wb_wd", WriteDataE, 32'h22);
`else
    chk("nofwd_a", SrcAE, 32'h99);
    chk("nofwd_b", SrcBE, 32'h77);
    RegWriteM = 0;
    #1;
    chk("nofwd_a2", SrcAE, 32'h99);
`endif
    RsD = 5'd0; RtD = 5'd4; RD1D = 32'h55;
    RegWriteM = 1; WriteRegM = 5'd0;
    tick();
    chk("r0_nofwd", SrcAE, 32'h55);

    // stall then flush
    RegWriteM = 0; RegWriteW = 0;
    RD1D = 32'hA1; RD2D = 32'hA2; RsD = 5'd10; RtD = 5'd11; RdD = 5'd12;
    RegDstD = 1; ALUControlD = 3'b100; MemWriteD = 1; MemtoRegD = 1;
    tick();
    StallE = 1;
    RD1D = 32'hB1; RD2D = 32'hB2; RsD = 5'd13; RdD = 5'd14;
    ALUControlD = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_a", SrcAE, 32'hA1);
      chk("stall_wr", {27'b0, WriteRegE}, 32'd12);
      chk("stall_alu", {29'b0, ALUControlE}, 32'd4);
    end
`ifdef ID_EX_FORWARDING_EN
    RegWriteW = 1; WriteRegW = 5'd10; ResultW = 32'h3C;
    #1;
    chk("stall_fwd", SrcAE, 32'h3C);
    tick();
    RegWriteW = 0;
`endif
    FlushE = 1;
    tick();
    chk_zero("flush");
    FlushE = 0;
    StallE = 0;
    tick();
    chk("after_flush", SrcAE, 32'hB1);

    // reset wins over stall
    StallE = 1;
    async_reset("rst_stall");
    StallE = 0;
    tick();
    chk("rst_release", SrcAE, 32'hB1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
